load_store_master: RTL and testbench

LOAD_STORE_MASTER -- requirements
Module: load_store_master

---
 rtl/load_store_master.sv | 205 ++++++++++++++++++++
 tb/tb_load_store_master.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_master.sv
`default_nettype none
// ============================================================================
// Module      : load_store_master
// Description : RV32I load/store sequencer between the pipeline and a
//               stall-capable data memory. Optional store stall watchdog is
//               compiled in with the LSU_STALL_TIMEOUT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_master (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_timeout,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_RD_CAPTURE = 3'd2,
        S_WR_WAIT    = 3'd3
`ifdef LSU_STALL_TIMEOUT_EN
        , S_WR_TMO   = 3'd4
`endif
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_ready_en;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [3:0]  r_mask;
    logic        r_resp_valid;
    logic        r_misaligned;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_illegal;
    logic [3:0]  w_mask;
    logic        w_resp_ok;
    logic        w_resp_err;
    logic        w_resp_tmo;

`ifdef LSU_STALL_TIMEOUT_EN
    logic [4:0]  r_cnt;
    logic        r_timeout;
`endif

    assign w_accept = req_valid & req_ready;

    // Legality depends on width code, direction and natural alignment.
    always_comb begin
        w_illegal = 1'b0;
        case (req_funct3)
            3'b000:  w_illegal = 1'b0;
            3'b001:  w_illegal = req_addr[0];
            3'b010:  w_illegal = (req_addr[1:0] != 2'b00);
            3'b100:  w_illegal = req_we;
            3'b101:  w_illegal = req_we | req_addr[0];
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_mask = 4'b0000;
        case (req_funct3[1:0])
            2'b00:   w_mask[2:0] = 3'b001;
            2'b01:   w_mask[2:0] = 3'b011;
            default: w_mask[2:0] = 3'b111;
        endcase
        // Only sub-word loads need sign extension in the memory.
        w_mask[3] = ~req_we & ~req_funct3[2] & (req_funct3[1:0] != 2'b10);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_resp_ok    = 1'b0;
        w_resp_err   = 1'b0;
        w_resp_tmo   = 1'b0;
        req_ready    = 1'b0;
        mem_memread  = 1'b0;
        mem_memwrite = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = r_ready_en;
                if (w_accept) begin
                    if (w_illegal) begin
                        w_resp_err = 1'b1;
                    end else begin
                        w_next_state = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                mem_memread  = ~r_we;
                mem_memwrite = r_we;
                w_next_state = r_we ? S_WR_WAIT : S_RD_CAPTURE;
            end
            S_RD_CAPTURE: begin
                w_resp_ok    = 1'b1;
                w_next_state = S_IDLE;
            end
            S_WR_WAIT: begin
                if (!mem_clk_stall) begin
                    w_resp_ok    = 1'b1;
                    w_next_state = S_IDLE;
                end
`ifdef LSU_STALL_TIMEOUT_EN
                else if (r_cnt == 5'd15) begin
                    // This stalled cycle is the 16th one.
                    w_next_state = S_WR_TMO;
                end
`endif
            end
`ifdef LSU_STALL_TIMEOUT_EN
            S_WR_TMO: begin
                w_resp_tmo   = 1'b1;
                w_next_state = S_IDLE;
            end
`endif
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready_en   <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_we         <= 1'b0;
            r_mask       <= 4'd0;
            r_resp_valid <= 1'b0;
            r_misaligned <= 1'b0;
            r_rdata      <= 32'd0;
        end else begin
            r_ready_en   <= 1'b1;
            r_resp_valid <= w_resp_ok | w_resp_err | w_resp_tmo;
            r_misaligned <= w_resp_err;
            if (w_accept && !w_illegal) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_we    <= req_we;
                r_mask  <= w_mask;
            end
            if (r_state == S_RD_CAPTURE) begin
                r_rdata <= mem_read_data;
            end
        end
    end

`ifdef LSU_STALL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 5'd0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_resp_tmo;
            if (r_state == S_ISSUE) begin
                r_cnt <= 5'd0;
            end else if (r_state == S_WR_WAIT && mem_clk_stall) begin
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    assign resp_timeout = r_timeout;
`else
    assign resp_timeout = 1'b0;
`endif

    assign resp_valid      = r_resp_valid;
    assign resp_misaligned = r_misaligned;
    assign resp_rdata      = r_rdata;
    assign mem_addr        = r_addr;
    assign mem_write_data  = r_wdata;
    assign mem_sign_mask   = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_load_store_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_master
// Description : Self-checking bench for load_store_master: vector table with
//               response scoreboard plus hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_timeout;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_read_data;
    logic        mem_clk_stall;

    load_store_master dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .resp_timeout    (resp_timeout),
        .mem_addr        (mem_addr),
        .mem_write_data  (mem_write_data),
        .mem_memwrite    (mem_memwrite),
        .mem_memread     (mem_memread),
        .mem_sign_mask   (mem_sign_mask),
        .mem_read_data   (mem_read_data),
        .mem_clk_stall   (mem_clk_stall)
    );

    always #5 clk = ~clk;

    // Memory stall model: stall rises the cycle after a write strobe.
    int stall_budget = 0;
    int stall_cnt    = 0;
    always @(posedge clk) begin
        if (mem_memwrite) stall_cnt <= stall_budget;
        else if (stall_cnt > 0) stall_cnt <= stall_cnt - 1;
    end
    assign mem_clk_stall = (stall_cnt != 0);

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        int          stall;
        logic        exp_mis;
        logic        exp_tmo;
        logic [3:0]  exp_mask;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic        mis;
        logic        tmo;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    localparam int NVEC = 17;
    vec_t        vecs [NVEC];
    exp_t        sb [$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_rdata = 32'd0;

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", what, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check($sformatf("%s_ctrl", tag),
              32'({req_ready, resp_valid, resp_misaligned, resp_timeout,
                   mem_memwrite, mem_memread, mem_sign_mask}), 32'd0);
        check($sformatf("%s_mem_addr", tag), mem_addr, 32'd0);
        check($sformatf("%s_mem_wdata", tag), mem_write_data, 32'd0);
        check($sformatf("%s_rdata", tag), resp_rdata, 32'd0);
    endtask

    task automatic wait_stall_clear(input string tag);
        for (int i = 0; i < 64 && mem_clk_stall; i++) @(negedge clk);
        check($sformatf("%s_stall_clear", tag), 32'(mem_clk_stall), 32'd0);
    endtask

    task automatic run_req(input vec_t v, input string tag);
        exp_t e;
        exp_t g;
        int   lat;
        int   nrd;
        int   nwr;
        bit   got;
        bit   moved;
        logic legal_ld;
        logic legal_st;
        wait_stall_clear(tag);
        @(negedge clk);
        req_we        = v.we;
        req_funct3    = v.f3;
        req_addr      = v.addr;
        req_wdata     = v.wdata;
        mem_read_data = v.mrd;
        stall_budget  = v.stall;
        req_valid     = 1'b1;
        check($sformatf("%s_ready", tag), 32'(req_ready), 32'd1);
        legal_ld = !v.we && !v.exp_mis;
        legal_st = v.we && !v.exp_mis;
        e.mis    = v.exp_mis;
        e.tmo    = v.exp_tmo;
        e.rdata  = legal_ld ? v.mrd : last_rdata;
        e.lat    = v.exp_lat;
        last_rdata = e.rdata;
        sb.push_back(e);
        @(negedge clk);
        // Scramble request inputs to prove the DUT works from latched copies.
        req_valid = 1'b0;
        req_addr  = ~v.addr;
        req_wdata = ~v.wdata;
        nrd = 0; nwr = 0; got = 1'b0; moved = 1'b0; lat = 0;
        for (int c = 1; c <= 40; c++) begin
            if (mem_memread || mem_memwrite) begin
                nrd += int'(mem_memread);
                nwr += int'(mem_memwrite);
                check($sformatf("%s_mask", tag), 32'(mem_sign_mask), 32'(v.exp_mask));
                check($sformatf("%s_addr", tag), mem_addr, v.addr);
                if (v.we) check($sformatf("%s_wdata", tag), mem_write_data, v.wdata);
            end else if (!resp_valid && (nrd + nwr) > 0) begin
                if (mem_addr !== v.addr || mem_sign_mask !== v.exp_mask ||
                    (v.we && mem_write_data !== v.wdata)) moved = 1'b1;
            end
            if (resp_valid) begin
                lat = c;
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s_resp: got no response, expected one within 40 cycles", tag);
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s_sb: got a response, expected none pending", tag);
        end else begin
            g = sb.pop_front();
            check($sformatf("%s_lat", tag), 32'(lat), 32'(g.lat));
            check($sformatf("%s_mis", tag), 32'(resp_misaligned), 32'(g.mis));
            check($sformatf("%s_tmo", tag), 32'(resp_timeout), 32'(g.tmo));
            check($sformatf("%s_rdata", tag), resp_rdata, g.rdata);
            check($sformatf("%s_ready_resp", tag), 32'(req_ready), 32'd1);
        end
        check($sformatf("%s_nread", tag), 32'(nrd), 32'(legal_ld));
        check($sformatf("%s_nwrite", tag), 32'(nwr), 32'(legal_st));
        check($sformatf("%s_stable", tag), 32'(moved), 32'd0);
        @(negedge clk);
        check($sformatf("%s_pulse", tag), 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int nrd;
        bit seen;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; mem_read_data = 32'd0;

        // we, f3, addr, wdata, mem rdata, stall, mis, tmo, mask, latency
        vecs[0]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'h8000_00FF, 0, 1'b0, 1'b0, 4'b0111, 3};
        vecs[1]  = '{1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFF_FF80, 0, 1'b0, 1'b0, 4'b1001, 3};
        vecs[2]  = '{1'b1, 3'b001, 32'h22, 32'h1234ABCD, 32'hDEAD_BEEF, 1, 1'b0, 1'b0, 4'b0011, 4};
        vecs[3]  = '{1'b0, 3'b010, 32'h06, 32'h0,        32'h1111_1111, 0, 1'b1, 1'b0, 4'b0000, 1};
        vecs[4]  = '{1'b1, 3'b001, 32'h01, 32'h5555,     32'h2222_2222, 1, 1'b1, 1'b0, 4'b0000, 1};
        vecs[5]  = '{1'b0, 3'b101, 32'h02, 32'h0,        32'h0000_BEEF, 0, 1'b0, 1'b0, 4'b0011, 3};
        vecs[6]  = '{1'b0, 3'b001, 32'h04, 32'h0,        32'hFFFF_8001, 0, 1'b0, 1'b0, 4'b1011, 3};
        vecs[7]  = '{1'b0, 3'b100, 32'h07, 32'h0,        32'h0000_007F, 0, 1'b0, 1'b0, 4'b0001, 3};
        vecs[8]  = '{1'b1, 3'b000, 32'h05, 32'h0000_00AB, 32'h3333_3333, 0, 1'b0, 1'b0, 4'b0001, 3};
        vecs[9]  = '{1'b1, 3'b010, 32'h08, 32'hC0FF_EE00, 32'h4444_4444, 3, 1'b0, 1'b0, 4'b0111, 6};
        vecs[10] = '{1'b0, 3'b011, 32'h00, 32'h0,        32'h5555_5555, 0, 1'b1, 1'b0, 4'b0000, 1};
        vecs[11] = '{1'b1, 3'b100, 32'h00, 32'h77,       32'h6666_6666, 0, 1'b1, 1'b0, 4'b0000, 1};
        vecs[12] = '{1'b0, 3'b111, 32'h00, 32'h0,        32'h7777_7777, 0, 1'b1, 1'b0, 4'b0000, 1};
        vecs[13] = '{1'b0, 3'b001, 32'h03, 32'h0,        32'h8888_8888, 0, 1'b1, 1'b0, 4'b0000, 1};
        vecs[14] = '{1'b1, 3'b010, 32'h02, 32'h9999,     32'h9999_9999, 0, 1'b1, 1'b0, 4'b0000, 1};
        vecs[15] = '{1'b0, 3'b110, 32'h00, 32'h0,        32'hAAAA_AAAA, 0, 1'b1, 1'b0, 4'b0000, 1};
`ifdef LSU_STALL_TIMEOUT_EN
        vecs[16] = '{1'b1, 3'b010, 32'h40, 32'h55AA_55AA, 32'hBBBB_BBBB, 20, 1'b0, 1'b1, 4'b0111, 19};
`else
        vecs[16] = '{1'b1, 3'b010, 32'h40, 32'h55AA_55AA, 32'hBBBB_BBBB, 20, 1'b0, 1'b0, 4'b0111, 23};
`endif

        // Reset state and release behaviour.
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        #1;
        check("ready_before_clk", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("ready_after_clk", 32'(req_ready), 32'd1);

        for (int i = 0; i < NVEC; i++) run_req(vecs[i], $sformatf("v%0d", i));

        // Back-to-back: valid held high, second request taken in the response cycle.
        wait_stall_clear("b2b");
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
        mem_read_data = 32'hA5A5_5A5A; stall_budget = 0; req_valid = 1'b1;
        nrd = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            nrd += int'(mem_memread);
            if (c == 1) check("b2b_busy_ready", 32'(req_ready), 32'd0);
            if (c == 3) begin
                check("b2b_resp1", 32'(resp_valid), 32'd1);
                check("b2b_rdata1", resp_rdata, 32'hA5A5_5A5A);
                check("b2b_ready_in_resp", 32'(req_ready), 32'd1);
            end
            if (c == 4) begin
                check("b2b_issue2", 32'(mem_memread), 32'd1);
                req_valid = 1'b0;
                mem_read_data = 32'h0F0F_0F0F;
            end
            if (c == 5) check("b2b_no_resp", 32'(resp_valid), 32'd0);
            if (c == 6) begin
                check("b2b_resp2", 32'(resp_valid), 32'd1);
                check("b2b_rdata2", resp_rdata, 32'h0F0F_0F0F);
            end
        end
        check("b2b_nread", 32'(nrd), 32'd2);

        // Reset while a store waits on the memory stall.
        wait_stall_clear("rst_mid");
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h50;
        req_wdata = 32'hCAFE_F00D; stall_budget = 5; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid_memwrite", 32'(mem_memwrite), 32'd1);
        repeat (2) @(negedge clk);
        check("rst_mid_in_wait", 32'(mem_clk_stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check("rst_mid_no_resp", 32'(seen), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        last_rdata = 32'd0;
        run_req('{1'b0, 3'b010, 32'h30, 32'h0, 32'h1357_9BDF, 0, 1'b0, 1'b0, 4'b0111, 3}, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
